// File: rtl/matmul2x2_sched.sv
// matmul2x2_sched: 2x2 8-bit matrix multiplier shared between two request ports.
// A single 8x8 multiplier and 17-bit adder run one job at a time over 8 steps.
// Build option: define MATMUL_SAT_EN to saturate result elements at 255 instead
// of wrapping them modulo 256.
module matmul2x2_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic [15:0] job_count
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompute = 2'd1,
        StResp    = 2'd2
    } state_e;

    state_e      r_state;
    logic        r_ptr;
    logic        r_owner;
    logic [2:0]  r_step;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [16:0] r_acc [4];
    logic [1:0]  r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [15:0] r_job_count;

    logic [1:0]  w_elem;
    logic        w_term;
    logic [1:0]  w_a_idx;
    logic [1:0]  w_b_idx;
    logic [7:0]  w_a_el;
    logic [7:0]  w_b_el;
    logic [15:0] w_prod;
    logic [16:0] w_sum;
    logic [1:0]  w_grant;
    logic        w_win;

    // Element idx = 2*row + col, packed m00 in the top byte.
    function automatic logic [7:0] elem_at(input logic [31:0] m, input logic [1:0] idx);
        case (idx)
            2'd0:    elem_at = m[31:24];
            2'd1:    elem_at = m[23:16];
            2'd2:    elem_at = m[15:8];
            default: elem_at = m[7:0];
        endcase
    endfunction

    function automatic logic [7:0] clip(input logic [16:0] acc);
`ifdef MATMUL_SAT_EN
        clip = (acc > 17'd255) ? 8'hFF : acc[7:0];
`else
        clip = acc[7:0];
`endif
    endfunction

    // Step k: element e = k>>1 at (i,j) = (e>>1, e&1), term t = k&1.
    assign w_elem  = r_step[2:1];
    assign w_term  = r_step[0];
    assign w_a_idx = {w_elem[1], w_term};
    assign w_b_idx = {w_term, w_elem[0]};
    assign w_a_el  = elem_at(r_a, w_a_idx);
    assign w_b_el  = elem_at(r_b, w_b_idx);
    assign w_prod  = {8'd0, w_a_el} * {8'd0, w_b_el};
    assign w_sum   = (w_term ? r_acc[w_elem] : 17'd0) + {1'b0, w_prod};

    // Combinational round-robin arbitration, only live in IDLE out of reset.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == StIdle && rst) begin
            if (req_valid == 2'b11) begin
                w_grant = r_ptr ? 2'b10 : 2'b01;
            end else begin
                w_grant = req_valid;
            end
        end
    end

    assign w_win     = w_grant[1];
    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != StIdle);
    assign job_count = r_job_count;

    // Job FSM: accept, 8 multiply/accumulate steps, then hold the response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_step      <= 3'd0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= 17'd0;
            end
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= 32'd0;
            r_job_count <= 16'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_grant != 2'b00) begin
                        r_owner <= w_win;
                        r_ptr   <= ~w_win;
                        r_step  <= 3'd0;
                        r_a     <= w_win ? a1 : a0;
                        r_b     <= w_win ? b1 : b0;
                        r_state <= StCompute;
                    end
                end
                StCompute: begin
                    r_acc[w_elem] <= w_sum;
                    r_step        <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_state     <= StResp;
                        r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                        // Last element comes straight from the adder on this step.
                        r_rsp_data  <= {clip(r_acc[0]), clip(r_acc[1]), clip(r_acc[2]),
                                        clip(w_sum)};
                    end
                end
                StResp: begin
                    if (rsp_ready[r_owner]) begin
                        r_state     <= StIdle;
                        r_rsp_valid <= 2'b00;
                        r_rsp_data  <= 32'd0;
                        r_job_count <= r_job_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul2x2_sched.sv
// Self-checking bench for matmul2x2_sched: directed scenarios plus random jobs
// compared against a plain-arithmetic matrix product model.
module tb_matmul2x2_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic [15:0] job_count;

    int checks   = 0;
    int failures = 0;

    // Model state: round-robin pointer, completed jobs, current job.
    int          m_ptr   = 0;
    int          m_count = 0;
    int          m_owner = 0;
    logic [31:0] m_exp   = 32'd0;

`ifdef MATMUL_SAT_EN
    localparam logic [31:0] OvfExp = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OvfExp = 32'h0000_0000;
`endif

    matmul2x2_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .job_count (job_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mm(input logic [31:0] a, input logic [31:0] b);
        int          am [2][2];
        int          bm [2][2];
        int          s;
        logic [31:0] r;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                am[i][j] = int'(a[31 - 8 * (2 * i + j) -: 8]);
                bm[i][j] = int'(b[31 - 8 * (2 * i + j) -: 8]);
            end
        end
        r = 32'd0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
`ifdef MATMUL_SAT_EN
                if (s > 255) s = 255;
`else
                s = s % 256;
`endif
                r[31 - 8 * (2 * i + j) -: 8] = 8'(s);
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] ref_grant(input logic [1:0] rv, input int ptr);
        if (rv == 2'b11) return (ptr == 1) ? 2'b10 : 2'b01;
        return rv;
    endfunction

    // Called at an IDLE negedge with requests already driven; returns at the
    // negedge of the first response cycle (accept + 9).
    task automatic run_job(input bit scramble);
        logic [1:0] g;
        #1;
        g = ref_grant(req_valid, m_ptr);
        check("req_ready_idle", {30'd0, req_ready}, {30'd0, g});
        m_owner = g[1] ? 1 : 0;
        m_exp   = g[1] ? ref_mm(a1, b1) : ref_mm(a0, b0);
        m_ptr   = 1 - m_owner;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("busy_compute", {31'd0, busy}, 32'd1);
            check("rsp_valid_compute", {30'd0, rsp_valid}, 32'd0);
            check("rsp_data_compute", rsp_data, 32'd0);
            if (scramble) begin
                req_valid = 2'($urandom_range(0, 3));
                rsp_ready = 2'($urandom_range(0, 3));
                a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
                #1;
                check("req_ready_busy", {30'd0, req_ready}, 32'd0);
            end
        end
        @(negedge clk);
        check("rsp_valid_resp", {30'd0, rsp_valid}, (m_owner == 1) ? 32'd2 : 32'd1);
        check("rsp_data_resp", rsp_data, m_exp);
        if (scramble) begin
            req_valid = 2'b00;
            rsp_ready = 2'b00;
        end
    endtask

    // Called at a RESP negedge; drives rsp_ready and checks the return to IDLE.
    task automatic complete(input logic [1:0] rdy);
        rsp_ready = rdy;
        @(negedge clk);
        m_count = (m_count + 1) % 65536;
        check("rsp_valid_done", {30'd0, rsp_valid}, 32'd0);
        check("rsp_data_done", rsp_data, 32'd0);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("job_count", {16'd0, job_count}, m_count);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    // Hold the response for n cycles with the given rsp_ready, checking it stays put.
    task automatic hold_resp(input int n, input logic [1:0] rdy);
        for (int k = 0; k < n; k++) begin
            rsp_ready = rdy;
            req_valid = 2'b11;
            @(negedge clk);
            check("hold_rsp_data", rsp_data, m_exp);
            check("hold_rsp_valid", {30'd0, rsp_valid}, (m_owner == 1) ? 32'd2 : 32'd1);
            check("hold_req_ready", {30'd0, req_ready}, 32'd0);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
        @(negedge clk);
        @(negedge clk);

        // Reset state, requests must be refused while in reset.
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_job_count", {16'd0, job_count}, 32'd0);

        // Basic known product on port 0.
        rst = 1'b1; req_valid = 2'b01; a0 = 32'h0102_0304; b0 = 32'h0506_0708;
        run_job(1'b0);
        check("basic_const", rsp_data, 32'h1316_2B32);
        complete(2'b01);

        // Overflow on port 0 alone while the pointer favours port 1.
        req_valid = 2'b01; a0 = 32'h1010_1010; b0 = 32'h1010_1010;
        run_job(1'b1);
        check("overflow_const", rsp_data, OvfExp);
        complete(2'b01);

        // Both request: pointer picks port 1; backpressure then non-owner ready.
        req_valid = 2'b11;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        run_job(1'b1);
        hold_resp(5, 2'b00);
        hold_resp(3, 2'b01);
        complete(2'b10);

        // Port 0 job with only port 1 ready: must stay pending.
        req_valid = 2'b01; a0 = $urandom; b0 = $urandom;
        run_job(1'b1);
        hold_resp(4, 2'b10);
        complete(2'b01);

        // Reset at COMPUTE step 4 abandons the job.
        req_valid = 2'b01; a0 = $urandom; b0 = $urandom;
        #1;
        check("mid_req_ready", {30'd0, req_ready}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 2'b00;
        end
        rst = 1'b0; req_valid = 2'b11;
        @(negedge clk);
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("mid_job_count", {16'd0, job_count}, 32'd0);
        check("mid_req_ready_rst", {30'd0, req_ready}, 32'd0);
        m_count = 0; m_ptr = 0;
        rst = 1'b1; req_valid = 2'b00;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("mid_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        run_job(1'b0);
        complete(2'b01);

        // Continuous requests on both ports from reset release alternate grants.
        rst = 1'b0;
        @(negedge clk);
        m_count = 0; m_ptr = 0;
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        for (int n = 0; n < 4; n++) begin
            run_job(1'b0);
            check("arb_owner", m_owner, n % 2);
            @(negedge clk);
            m_count++;
            check("arb_rsp_cleared", {30'd0, rsp_valid}, 32'd0);
        end
        check("arb_job_count", {16'd0, job_count}, 32'd4);
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Random jobs with random request patterns.
        for (int n = 0; n < 8; n++) begin
            req_valid = 2'($urandom_range(1, 3));
            a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
            run_job(1'b1);
            complete((m_owner == 1) ? 2'b10 : 2'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul2x2_sched.md
MATMUL2X2_SCHED -- requirements
Module: matmul2x2_sched

Interface
REQ-001 The block SHALL provide these ports; reset rst is synchronous, active-low, and the clock is clk:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  2  per-port job request; bit p belongs to port p.
- req_ready  out  2  per-port grant/accept strobe.
- a0, b0  in  32 each  port-0 operands.
- a1, b1  in  32 each  port-1 operands.
- rsp_valid  out  2  per-port result valid.
- rsp_ready  in  2  per-port result consume.
- rsp_data  out  32  result matrix.
- busy  out  1  high whenever state is not IDLE.
- job_count  out  16  completed-job counter.
REQ-002 Matrix packing for operands and result SHALL be: [31:24]=m00, [23:16]=m01, [15:8]=m10, [7:0]=m11, with each element 8-bit unsigned.

Function
REQ-003 The block SHALL own one 8x8 multiplier and one 17-bit adder, and SHALL time-share them between ports 0 and 1, one job at a time.
REQ-004 The FSM SHALL have exactly these states: IDLE, COMPUTE, RESP.
REQ-005 In IDLE, arbitration SHALL be combinational:
- req_ready[p] is high only for the single winning port, and only in IDLE.
- If both ports request, the port named by the round-robin pointer wins.
- If one port requests, it wins regardless of the pointer.
REQ-006 On accept (req_valid[p] & req_ready[p]):
- Operands a_p and b_p are latched.
- The owner is set to p.
- The pointer is set to the other port.
- Step counter is set to 0.
- The FSM moves to COMPUTE.
REQ-007 COMPUTE SHALL last exactly 8 cycles with step k = 0..7, where element e = k>>1 and term t = k&1:
- t=0: acc[e] = product.
- t=1: acc[e] = acc[e] + product.
REQ-008 The product at each step SHALL be a[i][t]*b[t][j], where (i,j) = (e>>1, e&1); each product is 16 bits and each accumulator is 17 bits.
REQ-009 After step 7 the FSM SHALL enter RESP:
- rsp_valid[owner] = 1 and the other rsp_valid bit = 0.
- rsp_data = the four packed result elements.
REQ-010 Latency: if accept occurs in cycle T, rsp_valid SHALL first be high in cycle T+9.
REQ-011 RESP behaviour:
- rsp_valid and rsp_data SHALL hold stable until rsp_ready[owner] is sampled high.
- On that cycle the FSM SHALL return to IDLE and job_count SHALL increment, wrapping 0xFFFF->0x0000.
- rsp_ready of the non-owner port SHALL be ignored.
REQ-012 While state is not IDLE:
- req_ready SHALL be 2'b00.
- Changes on req_valid and the operand inputs SHALL have no effect.
REQ-013 A req_valid that drops before it is accepted SHALL leave no state change.
REQ-014 rsp_ready asserted outside RESP SHALL be ignored.
REQ-015 Each result element SHALL be derived from its 17-bit accumulator by default as acc[7:0] (modulo-256 wrap).
REQ-016 rsp_data SHALL read 0 whenever rsp_valid is 2'b00.

Reset
REQ-017 While rst=0 at a clock edge, the block SHALL set:
- state = IDLE, pointer = 0 (port 0 has priority).
- owner = 0, step counter = 0.
- All accumulators and latched operands = 0.
- job_count = 0, rsp_valid = 0, rsp_data = 0, busy = 0.
REQ-018 Reset asserted during COMPUTE or RESP SHALL abandon the job:
- No rsp_valid pulse is produced.
- job_count is not incremented.
REQ-019 req_ready SHALL be 0 in any cycle where rst=0.

Configuration
REQ-020 When macro MATMUL_SAT_EN is defined, each result element SHALL be min(acc, 255) (unsigned saturation); when undefined, REQ-015 wrap applies.
REQ-021 MATMUL_SAT_EN SHALL NOT change latency, handshake, or any other behaviour.

Verification
REQ-022 Basic: port 0 requests with a0=0x01020304, b0=0x05060708 -> rsp_valid=2'b01 nine cycles after accept, rsp_data=0x13162B32.
REQ-023 Overflow: a0=b0=0x10101010 -> rsp_data=0x00000000 with MATMUL_SAT_EN undefined, 0xFFFFFFFF with it defined.
REQ-024 Arbitration: both ports request continuously from reset release, with rsp_ready=2'b11 -> grants follow the order port0, port1, port0, port1, and job_count=4 after four responses.
REQ-025 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_data stable, req_ready=0 and busy=1 throughout; completes on the cycle rsp_ready[owner] is high.
REQ-026 Reset mid-job: rst=0 at COMPUTE step 4 -> no rsp_valid, job_count=0, busy=0, next request served normally with correct result.
REQ-027 Non-owner ready: rsp_ready=2'b10 while owner=0 -> no completion; the response stays pending.
